// File: rtl/l2_lru_lock_ctrl.sv
// Control-port sequencer/arbiter for l2_cache_lru: lock-clear sweep,
// then access > fill > unlock arbitration with a shadow lock bitmap.
module l2_lru_lock_ctrl #(
  parameter int NUM_SETS     = 4,
  parameter int NUM_WAYS     = 8,
  parameter int MAX_LOCKED   = NUM_WAYS - 1,
  parameter int STARVE_LIMIT = 4,
  localparam int SW = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WW = $clog2(NUM_WAYS),
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          init_done,
  input  logic          acc_req,
  input  logic [SW-1:0] acc_req_set,
  input  logic          acc_update_en,
  input  logic [WW-1:0] acc_update_way,
  input  logic          fill_req,
  input  logic [SW-1:0] fill_req_set,
  input  logic          fill_req_lock,
  output logic          fill_grant,
  output logic [WW-1:0] fill_grant_way,
  output logic          fill_lock_rejected,
  input  logic          unlock_req,
  input  logic [SW-1:0] unlock_set,
  input  logic [WW-1:0] unlock_way,
  output logic          unlock_ack,
  output logic          unlock_was_locked,
  output logic          fill_en,
  output logic [SW-1:0] fill_set,
  output logic          lock_en,
  output logic          lock_value,
  output logic          access_en,
  output logic [SW-1:0] access_set,
  output logic          access_update_en,
  output logic [WW-1:0] access_update_way,
  input  logic [WW-1:0] fill_way
);

  typedef enum logic [1:0] {
    INIT_ISSUE,
    INIT_UPDATE,
    RUN
  } state_e;

  state_e state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [WW-1:0] w_q, w_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] bitmap_q, bitmap_d;
  logic acc_pend_q, acc_pend_d;
  logic unlock_upd_pend_q, unlock_upd_pend_d;
  logic [WW-1:0] unl_way_q, unl_way_d;
  logic [CW-1:0] starve_q, starve_d;

  logic starved;
  logic do_acc, do_fill, do_unl;

  function automatic logic [WW:0] popc(
    input logic [NUM_WAYS-1:0] v
  );
    popc = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      popc = popc + {{WW{1'b0}}, v[i]};
  endfunction

  assign starved = (starve_q >= CW'(STARVE_LIMIT));
  // One-hot issue selection; starvation lets unlock jump ahead of fill
  assign do_acc  = acc_req;
  assign do_unl  = !acc_req && unlock_req &&
                   (starved || !fill_req);
  assign do_fill = !acc_req && fill_req && !do_unl;

  always_comb begin
    state_d            = state_q;
    s_d                = s_q;
    w_d                = w_q;
    bitmap_d           = bitmap_q;
    acc_pend_d         = acc_pend_q;
    unlock_upd_pend_d  = unlock_upd_pend_q;
    unl_way_d          = unl_way_q;
    starve_d           = starve_q;
    init_done          = 1'b0;
    fill_grant         = 1'b0;
    fill_grant_way     = '0;
    fill_lock_rejected = 1'b0;
    unlock_ack         = 1'b0;
    unlock_was_locked  = 1'b0;
    fill_en            = 1'b0;
    fill_set           = '0;
    lock_en            = 1'b0;
    lock_value         = 1'b0;
    access_en          = 1'b0;
    access_set         = '0;
    access_update_en   = 1'b0;
    access_update_way  = '0;
    if (!reset) begin
      unique case (state_q)
        INIT_ISSUE: begin
          access_en  = 1'b1;
          access_set = s_q;
          lock_en    = 1'b1;
          state_d    = INIT_UPDATE;
        end
        INIT_UPDATE: begin
          access_update_en  = 1'b1;
          access_update_way = w_q;
          if (w_q == WW'(NUM_WAYS - 1) &&
              s_q == SW'(NUM_SETS - 1)) begin
            state_d = RUN;
          end else begin
            state_d = INIT_ISSUE;
            w_d     = w_q + WW'(1);
            if (w_q == WW'(NUM_WAYS - 1))
              s_d = s_q + SW'(1);
          end
        end
        RUN: begin
          init_done         = 1'b1;
          acc_pend_d        = 1'b0;
          unlock_upd_pend_d = 1'b0;
          if (acc_pend_q) begin
            access_update_en  = acc_update_en;
            access_update_way = acc_update_way;
          end
          if (unlock_upd_pend_q) begin
            access_update_en  = 1'b1;
            access_update_way = unl_way_q;
          end
          if (!unlock_req)
            starve_d = '0;
          unique case (1'b1)
            do_acc: begin
              access_en  = 1'b1;
              access_set = acc_req_set;
              acc_pend_d = 1'b1;
            end
            do_fill: begin
              fill_en        = 1'b1;
              fill_set       = fill_req_set;
              fill_grant     = 1'b1;
              fill_grant_way = fill_way;
              if (fill_req_lock) begin
                if (popc(bitmap_q[fill_req_set]) <
                    (WW+1)'(MAX_LOCKED)) begin
                  lock_en    = 1'b1;
                  lock_value = 1'b1;
                  bitmap_d[fill_req_set][fill_way] = 1'b1;
                end else begin
                  fill_lock_rejected = 1'b1;
                end
              end
              if (unlock_req && !starved)
                starve_d = starve_q + CW'(1);
            end
            do_unl: begin
              access_en         = 1'b1;
              access_set        = unlock_set;
              lock_en           = 1'b1;
              unlock_ack        = 1'b1;
              unlock_was_locked =
                bitmap_q[unlock_set][unlock_way];
              bitmap_d[unlock_set][unlock_way] = 1'b0;
              unlock_upd_pend_d = 1'b1;
              unl_way_d         = unlock_way;
              starve_d          = '0;
            end
            default: ;
          endcase
        end
        default: state_d = INIT_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= INIT_ISSUE;
      s_q               <= '0;
      w_q               <= '0;
      bitmap_q          <= '0;
      acc_pend_q        <= 1'b0;
      unlock_upd_pend_q <= 1'b0;
      unl_way_q         <= '0;
      starve_q          <= '0;
    end else begin
      state_q           <= state_d;
      s_q               <= s_d;
      w_q               <= w_d;
      bitmap_q          <= bitmap_d;
      acc_pend_q        <= acc_pend_d;
      unlock_upd_pend_q <= unlock_upd_pend_d;
      unl_way_q         <= unl_way_d;
      starve_q          <= starve_d;
    end
  end

endmodule

// File: tb/tb_l2_lru_lock_ctrl.sv
// Bench for l2_lru_lock_ctrl: directed vectors, corner sequences and
// randomized traffic against a per-cycle behavioural model.
module tb_l2_lru_lock_ctrl;
  localparam int NS = 4, NW = 8, SW = 2, WW = 3;
  localparam int MAXL = 7, SL = 4;

  typedef logic [19:0] ovec_t;
  typedef struct {
    logic fr, fl;
    logic [SW-1:0] fs;
    int eg, el, er;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic init_done;
  logic acc_req, acc_update_en;
  logic [SW-1:0] acc_req_set;
  logic [WW-1:0] acc_update_way;
  logic fill_req, fill_req_lock;
  logic [SW-1:0] fill_req_set;
  logic fill_grant, fill_lock_rejected;
  logic [WW-1:0] fill_grant_way;
  logic unlock_req, unlock_ack, unlock_was_locked;
  logic [SW-1:0] unlock_set;
  logic [WW-1:0] unlock_way;
  logic fill_en, lock_en, lock_value;
  logic access_en, access_update_en;
  logic [SW-1:0] fill_set, access_set;
  logic [WW-1:0] access_update_way, fill_way;

  l2_lru_lock_ctrl dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .acc_req(acc_req), .acc_req_set(acc_req_set),
    .acc_update_en(acc_update_en),
    .acc_update_way(acc_update_way),
    .fill_req(fill_req), .fill_req_set(fill_req_set),
    .fill_req_lock(fill_req_lock),
    .fill_grant(fill_grant), .fill_grant_way(fill_grant_way),
    .fill_lock_rejected(fill_lock_rejected),
    .unlock_req(unlock_req), .unlock_set(unlock_set),
    .unlock_way(unlock_way), .unlock_ack(unlock_ack),
    .unlock_was_locked(unlock_was_locked),
    .fill_en(fill_en), .fill_set(fill_set),
    .lock_en(lock_en), .lock_value(lock_value),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en),
    .access_update_way(access_update_way),
    .fill_way(fill_way)
  );

  int nerr = 0, nchk = 0, cycle = 0;
  bit m_run;
  int m_swp, m_upd, m_starve;
  logic [WW-1:0] m_updway;
  bit m_lk [NS][NW];
  int e_kind;
  bit e_lockset;
  logic prev_acc = 1'b0;
  int s_done, s_grant, s_gway, s_rej, s_ack, s_was;
  int s_le, s_lv, s_ae, s_as, s_ue, s_uw;

  task automatic chk(input string name, input int act,
                     input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_locks(input logic [SW-1:0] s);
    int n = 0;
    for (int i = 0; i < NW; i++) n += int'(m_lk[s][i]);
    return n;
  endfunction

  function automatic logic [WW-1:0] pick_victim(
    input logic [SW-1:0] s);
    int q[$];
    for (int i = 0; i < NW; i++)
      if (!m_lk[s][i]) q.push_back(i);
    if (q.size() == 0) return '0;
    return WW'(q[$urandom_range(0, q.size() - 1)]);
  endfunction

  function automatic ovec_t model_out();
    logic id, g, rej, ack, was, fe, le, lv, ae, ue;
    logic [WW-1:0] gw, uw;
    logic [SW-1:0] fs, as;
    {id, g, rej, ack, was, fe, le, lv, ae, ue} = '0;
    gw = '0; uw = '0; fs = '0; as = '0;
    e_kind = 0; e_lockset = 0;
    if (!reset) begin
      if (!m_run) begin
        if (m_swp % 2 == 0) begin
          ae = 1; le = 1; as = SW'(m_swp / (2 * NW));
        end else begin
          ue = 1; uw = WW'((m_swp / 2) % NW);
        end
      end else begin
        id = 1;
        if (m_upd == 1) begin
          ue = acc_update_en; uw = acc_update_way;
        end else if (m_upd == 2) begin
          ue = 1; uw = m_updway;
        end
        if (acc_req) begin
          e_kind = 1; ae = 1; as = acc_req_set;
        end else if (unlock_req &&
                     (m_starve >= SL || !fill_req)) begin
          e_kind = 3; ae = 1; as = unlock_set; le = 1;
          ack = 1; was = m_lk[unlock_set][unlock_way];
        end else if (fill_req) begin
          e_kind = 2; fe = 1; fs = fill_req_set;
          g = 1; gw = fill_way;
          if (fill_req_lock) begin
            if (count_locks(fill_req_set) < MAXL) begin
              le = 1; lv = 1; e_lockset = 1;
            end else rej = 1;
          end
        end
      end
    end
    return {id, g, gw, rej, ack, was, fe, fs,
            le, lv, ae, as, ue, uw};
  endfunction

  function automatic void model_step();
    if (reset) begin
      m_run = 0; m_swp = 0; m_upd = 0; m_starve = 0;
      foreach (m_lk[i, j]) m_lk[i][j] = 0;
    end else if (!m_run) begin
      m_swp++;
      if (m_swp == 2 * NS * NW) m_run = 1;
    end else begin
      m_upd = (e_kind == 1) ? 1 : (e_kind == 3) ? 2 : 0;
      m_updway = unlock_way;
      if (e_kind == 3) m_lk[unlock_set][unlock_way] = 0;
      if (e_lockset) m_lk[fill_req_set][fill_way] = 1;
      if (!unlock_req || e_kind == 3) m_starve = 0;
      else if (e_kind == 2 && m_starve < SL) m_starve++;
    end
  endfunction

  task automatic cyc();
    ovec_t exp, act;
    acc_update_en = prev_acc;
    acc_update_way = WW'($urandom_range(0, NW - 1));
    fill_way = pick_victim(fill_req_set);
    @(negedge clk);
    exp = model_out();
    act = {init_done, fill_grant, fill_grant_way,
           fill_lock_rejected, unlock_ack, unlock_was_locked,
           fill_en, fill_set, lock_en, lock_value, access_en,
           access_set, access_update_en, access_update_way};
    s_done = int'(init_done); s_grant = int'(fill_grant);
    s_gway = int'(fill_grant_way);
    s_rej = int'(fill_lock_rejected);
    s_ack = int'(unlock_ack); s_was = int'(unlock_was_locked);
    s_le = int'(lock_en); s_lv = int'(lock_value);
    s_ae = int'(access_en); s_as = int'(access_set);
    s_ue = int'(access_update_en);
    s_uw = int'(access_update_way);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL model cycle %0d: outputs %h expected %h",
               cycle, act, exp);
    end
    @(posedge clk);
    model_step();
    prev_acc = acc_req;
    cycle++;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vec[8];
    int grants, lw;
    for (int i = 0; i < 8; i++)
      vec[i] = '{fr: 1'b1, fl: 1'b1, fs: 2'd2, eg: 1,
                 el: (i < 7) ? 1 : 0, er: (i < 7) ? 0 : 1};
    reset = 1; acc_req = 0; acc_req_set = '0;
    fill_req = 0; fill_req_set = '0; fill_req_lock = 0;
    unlock_req = 0; unlock_set = '0; unlock_way = '0;
    acc_update_en = 0; acc_update_way = '0; fill_way = '0;
    cyc(); cyc();
    chk("reset_init_done", s_done, 0);
    chk("reset_access_en", s_ae, 0);

    reset = 0; fill_req = 1;
    grants = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      grants += s_grant;
      if (i == 0) chk("sweep_first_lock", s_le, 1);
      if (i == 63) begin
        chk("sweep_last_way", s_uw, 7);
        chk("done_before_end", s_done, 0);
      end
    end
    chk("sweep_no_grant", grants, 0);
    cyc();
    chk("init_done_at_64", s_done, 1);
    chk("first_run_grant", s_grant, 1);
    fill_req = 0;

    lw = 0;
    for (int i = 0; i < 8; i++) begin
      fill_req = vec[i].fr; fill_req_lock = vec[i].fl;
      fill_req_set = vec[i].fs;
      cyc();
      chk($sformatf("vec%0d_grant", i), s_grant, vec[i].eg);
      chk($sformatf("vec%0d_lock_en", i), s_le, vec[i].el);
      chk($sformatf("vec%0d_reject", i), s_rej, vec[i].er);
      if (i == 0) lw = s_gway;
    end
    fill_req = 0; fill_req_lock = 0;

    unlock_req = 1; unlock_set = 2; unlock_way = WW'(lw);
    cyc();
    chk("unl_ack", s_ack, 1);
    chk("unl_was_locked", s_was, 1);
    chk("unl_set", s_as, 2);
    chk("unl_lock_value", s_lv, 0);
    unlock_req = 0;
    cyc();
    chk("unl_upd_en", s_ue, 1);
    chk("unl_upd_way", s_uw, lw);
    fill_req = 1; fill_req_lock = 1; fill_req_set = 2;
    cyc();
    chk("relock_lock_en", s_le, 1);
    chk("relock_reject", s_rej, 0);
    fill_req = 0; fill_req_lock = 0;
    cyc();

    acc_req = 1; acc_req_set = 1;
    fill_req = 1; fill_req_set = 3;
    unlock_req = 1; unlock_set = 1; unlock_way = 3;
    cyc();
    chk("trio0_access", s_ae, 1);
    chk("trio0_no_grant", s_grant + s_ack, 0);
    acc_req = 0;
    cyc();
    chk("trio1_grant", s_grant, 1);
    chk("trio1_acc_upd", s_ue, 1);
    fill_req = 0;
    cyc();
    chk("trio2_ack", s_ack, 1);
    chk("trio2_no_upd", s_ue, 0);
    unlock_req = 0;
    cyc();
    chk("trio3_unl_upd_way", s_ue * 8 + s_uw, 8 + 3);
    cyc();

    fill_req = 1; fill_req_set = 0;
    unlock_req = 1; unlock_set = 0; unlock_way = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("starve%0d_grant", i), s_grant,
          (i < 4) ? 1 : 0);
      chk($sformatf("starve%0d_ack", i), s_ack,
          (i == 4) ? 1 : 0);
    end
    fill_req = 0; unlock_req = 0;
    cyc();

    reset = 1; cyc(); reset = 0;
    for (int i = 0; i < 20; i++) cyc();
    reset = 1; cyc();
    chk("midsweep_reset_quiet", s_ae + s_ue, 0);
    reset = 0; cyc();
    chk("restart_set0", s_ae * 8 + s_as, 8);
    cyc();
    chk("restart_way0", s_ue * 8 + s_uw, 8);
    for (int i = 0; i < 62; i++) cyc();
    fill_req = 1; fill_req_lock = 1; fill_req_set = 2;
    cyc();
    chk("rerun_done", s_done, 1);
    cyc(); cyc();
    fill_req = 0; fill_req_lock = 0;
    unlock_req = 1; unlock_set = 2; unlock_way = 0;
    cyc();
    unlock_req = 0; reset = 1;
    cyc();
    reset = 0;
    cyc();
    chk("run_reset_restart", s_ae * 8 + s_as, 8);
    for (int i = 0; i < 63; i++) cyc();
    for (int w = 0; w < NW; w++) begin
      unlock_req = 1; unlock_set = 2; unlock_way = WW'(w);
      cyc();
      chk($sformatf("cleared_way%0d", w), s_ack * 2 + s_was, 2);
      unlock_req = 0;
      cyc();
    end

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      acc_req = ($urandom_range(0, 9) < 3);
      acc_req_set = SW'($urandom_range(0, NS - 1));
      if (!fill_req && $urandom_range(0, 3) == 0) begin
        fill_req = 1;
        fill_req_set = SW'($urandom_range(0, NS - 1));
        fill_req_lock = ($urandom_range(0, 2) != 0);
      end
      if (!unlock_req && $urandom_range(0, 7) == 0) begin
        unlock_req = 1;
        unlock_set = SW'($urandom_range(0, NS - 1));
        unlock_way = WW'($urandom_range(0, NW - 1));
      end
      cyc();
      if (s_grant != 0) fill_req = 0;
      if (s_ack != 0) unlock_req = 0;
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/l2_lru_lock_ctrl.md
# l2_lru_lock_ctrl

Sequencer and arbiter that owns the control port of `l2_cache_lru`. After reset it performs the lock-clear sweep over every set and way. It then shares the LRU between three requesters: the tag-lookup pipeline (access/update), the miss path (fill, optionally locking the victim) and the lock-management unit (unlock). It keeps a shadow lock bitmap and refuses any lock that would leave a set with no replaceable way.

## Interface
Parameters:
- NUM_SETS, 4, sets in the LRU; power of two, ≥1.
- NUM_WAYS, 8, ways per set; power of two, ≥2.
- MAX_LOCKED, NUM_WAYS-1, maximum locked ways per set.
- STARVE_LIMIT, 4, consecutive fill grants tolerated while an unlock waits.

Ports (SW = $clog2(NUM_SETS) with minimum 1; WW = $clog2(NUM_WAYS)):
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- init_done  out  1  high once the sweep completes; stays high until reset.
- acc_req  in  1  pipeline lookup; always honoured once init_done=1, never stalled.
- acc_req_set  in  SW  lookup set.
- acc_update_en  in  1  asserted exactly one cycle after acc_req.
- acc_update_way  in  WW  way to promote to MRU.
- fill_req  in  1  fill request; held until fill_grant.
- fill_req_set  in  SW  fill set.
- fill_req_lock  in  1  lock the victim way.
- fill_grant  out  1  fill issued this cycle.
- fill_grant_way  out  WW  victim way; equals fill_way, valid with fill_grant.
- fill_lock_rejected  out  1  with fill_grant: lock suppressed because the set is at MAX_LOCKED.
- unlock_req  in  1  unlock request; held until unlock_ack.
- unlock_set  in  SW  target set.
- unlock_way  in  WW  target way.
- unlock_ack  out  1  unlock issued this cycle.
- unlock_was_locked  out  1  with unlock_ack: the shadow bit was set.
- fill_en, fill_set, lock_en, lock_value, access_en, access_set, access_update_en, access_update_way  out  to the LRU, same widths as the LRU ports.
- fill_way  in  WW  victim from the LRU; combinational in the fill_en cycle.

## Operation
- States: INIT_ISSUE, INIT_UPDATE, RUN. A separate flag, unlock_upd_pend, covers the unlock update cycle.
- Sweep counters: set counter s, way counter w.
- INIT_ISSUE: access_en=1, access_set=s, lock_en=1, lock_value=0. Go to INIT_UPDATE.
- INIT_UPDATE: access_update_en=1, access_update_way=w, lock_en=0.
  - If w and s are both at their maximum, go to RUN.
  - Otherwise go to INIT_ISSUE with w incremented; when w wraps to 0, s increments.
- While not in RUN: acc_req, fill_req and unlock_req are ignored, and no grants or acks are issued.
- RUN: at most one issue per cycle. Priority: acc_req > fill > unlock.
  - Starvation override: if unlock_req has been pending through STARVE_LIMIT consecutive fill grants, unlock beats fill in the next cycle with no acc_req.
- Access issue: access_en=1, access_set=acc_req_set. The following cycle drives access_update_en=acc_update_en and access_update_way=acc_update_way, with no lock_en.
- Fill issue: fill_en=1, fill_set=fill_req_set, fill_grant=1, fill_grant_way=fill_way.
  - If fill_req_lock=1 and popcount(bitmap[set]) < MAX_LOCKED: drive lock_en=1, lock_value=1, and set bitmap[set][fill_way].
  - If fill_req_lock=1 and the set is already at MAX_LOCKED: fill proceeds without lock, fill_lock_rejected=1.
- Unlock issue:
  - Issue cycle: access_en=1, access_set=unlock_set, lock_en=1, lock_value=0, unlock_ack=1, unlock_was_locked=bitmap bit; then clear the bit.
  - Next cycle (unlock_upd_pend): access_update_en=1, access_update_way=unlock_way.
  - Unlocking an unlocked way is still issued, which is harmless, and reports was_locked=0.
- No slot collisions by construction. Every update cycle belongs to the single issue one cycle earlier, and issues are mutually exclusive. A new access, fill or unlock may issue in another op's update cycle.
- Popcount width is WW+1. Counters wrap naturally at power-of-two bounds.

## Timing
- Reset values: state=INIT_ISSUE, s=w=0, bitmap all 0, unlock_upd_pend=0, starvation count 0.
- During the reset cycle, every output is 0, including init_done, grants and all LRU drives.
- Sweep length: 2·NUM_SETS·NUM_WAYS cycles.
  - The first cycle after reset deasserts is INIT_ISSUE.
  - init_done rises in the first RUN cycle.
- All LRU outputs, grants and acks are combinational from current state and inputs: zero-cycle latency from request to issue. fill_grant_way depends combinationally on fill_way.
- Bitmap and starvation count update on the clock edge ending the issue cycle. A fill-lock followed immediately by an unlock of the same way sees the updated bit.
- Reset asserted mid-sweep or mid-operation: at the next edge, return to reset values.
  - A pending unlock update is dropped.
  - The sweep restarts from s=0, w=0.

## Test plan
- Reset, NUM_SETS=4, NUM_WAYS=8 → 64 sweep cycles alternating (access_en=1, lock_en=1, lock_value=0) and (access_update_en=1, way 0..7 per set); init_done=1 at cycle 64; fill_req held during the sweep gets no grant.
- Seven fill_req_lock=1 to set 2 → seven grants with lock_en=1, fill_lock_rejected=0; eighth → fill_grant=1, lock_en=0, fill_lock_rejected=1.
- Unlock set 2 on a way locked in the previous test → unlock_ack, was_locked=1, access_set=2/lock_value=0, then access_update_way=that way next cycle; a following fill_req_lock=1 to set 2 locks with no reject.
- Same-cycle acc_req, fill_req and unlock_req → access in cycle 0, fill in cycle 1, unlock in cycle 2; each access_update_en lands in the cycle after its issue with no overlap.
- Continuous fill_req and unlock_req, no acc_req → fills in cycles 0–3, unlock_ack in cycle 4.
- Reset mid-sweep at cycle 20, and again in RUN with set 2 holding locks → sweep restarts from set 0 way 0; afterwards unlock_was_locked=0 for every way.
